// File: rtl/imem_prefetch_if.sv
// Fetch-side bundle for imem_prefetch: control, instruction stream and load port.
//   master : drives start/halt/flush, out_ready and the load port, observes the stream
//   slave  : the prefetcher; drives the head entry, load_err and busy
interface imem_prefetch_if #(
   parameter int unsigned N   = 32,
   parameter int unsigned INS = 1000
);
   localparam int unsigned AW = $clog2(INS);

   // control
   logic          start;
   logic [N-1:0]  start_pc;
   logic          halt;
   logic          flush;
   logic [N-1:0]  flush_pc;
   // instruction stream (queue head)
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  instruction;
   logic [N-1:0]  out_pc;
   logic          out_oob;
   // runtime load port
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [N-1:0]  load_data;
   logic          load_err;
   // status
   logic          busy;

   modport master (
      output start, start_pc, halt, flush, flush_pc, out_ready,
             load_en, load_addr, load_data,
      input  out_valid, instruction, out_pc, out_oob, load_err, busy
   );

   modport slave (
      input  start, start_pc, halt, flush, flush_pc, out_ready,
             load_en, load_addr, load_data,
      output out_valid, instruction, out_pc, out_oob, load_err, busy
   );
endinterface

// File: rtl/imem_prefetch.sv
// Instruction memory with a 1-cycle synchronous read, an IDLE-only load port and a
// QDEPTH-entry prefetch queue streaming sequential instructions from a start PC.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (memory contents are kept)
//   bus  : imem_prefetch_if.slave - start/halt/flush control, head-of-queue stream
//          (out_valid/out_ready/instruction/out_pc/out_oob), load port, load_err, busy
module imem_prefetch #(
   parameter int unsigned N         = 32,
   parameter int unsigned INS       = 1000,
   parameter int unsigned QDEPTH    = 4,
   parameter bit          BYTE_ADDR = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   imem_prefetch_if.slave bus
);
   localparam int unsigned  AW   = $clog2(INS);
   localparam int unsigned  PW   = $clog2(QDEPTH);
   localparam int unsigned  CW   = PW + 1;
   localparam logic [N-1:0] STEP = BYTE_ADDR ? N'(4) : N'(1);

   typedef enum logic {IDLE, RUN} state_e;

   typedef struct packed {
      logic [N-1:0] ins;
      logic [N-1:0] pc;
      logic         oob;
   } entry_t;

   state_e        state_q, state_d;
   logic [N-1:0]  fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [N-1:0]  infl_pc_q, infl_pc_d;
   logic          infl_oob_q, infl_oob_d;
   entry_t        slot_q [QDEPTH];
   entry_t        slot_d [QDEPTH];
   logic [CW-1:0] count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic          load_err_q, load_err_d;
   logic          busy_q, busy_d;

   logic [N-1:0]  mem_q [INS];
   logic [N-1:0]  rdata_q;

   logic [N-1:0]  fetch_idx_c;
   logic          fetch_oob_c;
   logic [AW-1:0] rd_idx_c;
   logic          rd_en_c;
   logic          mem_we_c;
   logic          pop_c;
   logic          push_c;

   // Word index of the next fetch; in byte mode the low two PC bits are ignored.
   assign fetch_idx_c = BYTE_ADDR ? (fetch_pc_q >> 2) : fetch_pc_q;
   assign fetch_oob_c = (fetch_idx_c >= N'(INS));
   assign rd_idx_c    = fetch_idx_c[AW-1:0];

   // Next-state: queue shift/push, fetch issue, control and load decode.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      inflight_d  = 1'b0;
      infl_pc_d   = infl_pc_q;
      infl_oob_d  = infl_oob_q;
      slot_d      = slot_q;
      count_d     = count_q;
      load_err_d  = 1'b0;
      rd_en_c     = 1'b0;
      mem_we_c    = 1'b0;
      pop_c       = out_valid_q & bus.out_ready;
      push_c      = inflight_q;

      // Slot 0 is always the head; a pop shifts everything down one place.
      if (pop_c) begin
         for (int i = 0; i < int'(QDEPTH) - 1; i++) begin
            slot_d[i] = slot_q[i+1];
         end
      end
      // The read result lands behind the surviving entries; space was reserved at issue.
      if (push_c) begin
         slot_d[PW'(count_q - CW'(pop_c))] = '{ins: infl_oob_q ? '0 : rdata_q,
                                               pc:  infl_pc_q,
                                               oob: infl_oob_q};
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);

      if (bus.load_en) begin
         if ((state_q == IDLE) && (32'(bus.load_addr) < INS)) begin
            mem_we_c = 1'b1;
         end else begin
            load_err_d = 1'b1;
         end
      end

      if (bus.halt) begin
         state_d    = IDLE;
         count_d    = '0;
      end else if (state_q == RUN) begin
         if (bus.flush) begin
            count_d    = '0;
            fetch_pc_d = bus.flush_pc;
         end else if ((count_q + CW'(inflight_q)) < CW'(QDEPTH)) begin
            // Out-of-range fetches skip the array but still occupy a queue slot.
            rd_en_c    = ~fetch_oob_c;
            inflight_d = 1'b1;
            infl_pc_d  = fetch_pc_q;
            infl_oob_d = fetch_oob_c;
            fetch_pc_d = fetch_pc_q + STEP;
         end
      end else if (bus.start) begin
         state_d    = RUN;
         fetch_pc_d = bus.start_pc;
      end

      out_valid_d = (count_d != '0);
      busy_d      = (state_d == RUN);
   end

   // Control and queue state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= '0;
         inflight_q  <= 1'b0;
         infl_pc_q   <= '0;
         infl_oob_q  <= 1'b0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         load_err_q  <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < int'(QDEPTH); i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         inflight_q  <= inflight_d;
         infl_pc_q   <= infl_pc_d;
         infl_oob_q  <= infl_oob_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         load_err_q  <= load_err_d;
         busy_q      <= busy_d;
         slot_q      <= slot_d;
      end
   end

   // Storage array: not reset; loads only happen in IDLE so they never race a read.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[bus.load_addr] <= bus.load_data;
      end
      if (rd_en_c) begin
         rdata_q <= mem_q[rd_idx_c];
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.instruction = slot_q[0].ins;
   assign bus.out_pc      = slot_q[0].pc;
   assign bus.out_oob     = slot_q[0].oob;
   assign bus.load_err    = load_err_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_imem_prefetch.sv
// Randomised and directed bench for imem_prefetch: word-addressed instance checked
// against a stream-level reference model, byte-addressed instance with directed checks.
module tb_imem_prefetch;
   localparam int unsigned INS = 1000;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   imem_prefetch_if #(.N(32), .INS(INS)) ifa ();
   imem_prefetch_if #(.N(32), .INS(INS)) ifb ();

   imem_prefetch #(.N(32), .INS(INS), .QDEPTH(4), .BYTE_ADDR(1'b0)) dut_a (
      .clk(clk), .rst(rst_a), .bus(ifa));
   imem_prefetch #(.N(32), .INS(INS), .QDEPTH(4), .BYTE_ADDR(1'b1)) dut_b (
      .clk(clk), .rst(rst_b), .bus(ifb));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model for instance A: memory image plus the expected stream position.
   logic [31:0] ref_mem [INS];
   bit          m_run  = 1'b0;
   logic [31:0] m_pc   = '0;
   int          m_wait = 0;   // samples left until the first entry of a new stream

   function automatic logic [31:0] exp_ins_a(input logic [31:0] pc);
      if (pc >= INS) return 32'd0;
      return ref_mem[pc[9:0]];
   endfunction

   // Instance B only ever holds the initial image mem[i] = i + 100.
   function automatic logic [31:0] exp_ins_b(input logic [31:0] pc);
      logic [31:0] idx;
      idx = pc >> 2;
      if (idx >= INS) return 32'd0;
      return idx + 32'd100;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock for instance A with the current inputs, checked against the model.
   task automatic cyc_a();
      bit          acc, held, ctl, exp_err;
      logic [31:0] h_pc, h_ins;
      logic        h_oob;
      acc   = ifa.out_valid && ifa.out_ready;
      held  = ifa.out_valid && !ifa.out_ready;
      h_pc  = ifa.out_pc;
      h_ins = ifa.instruction;
      h_oob = ifa.out_oob;
      if (acc) begin
         chk("a_pc",  ifa.out_pc,      m_pc);
         chk("a_ins", ifa.instruction, exp_ins_a(m_pc));
         chk("a_oob", ifa.out_oob,     m_pc >= INS);
         m_pc = m_pc + 1;
      end
      exp_err = 1'b0;
      if (ifa.load_en) begin
         if (!m_run && (32'(ifa.load_addr) < INS)) ref_mem[ifa.load_addr] = ifa.load_data;
         else exp_err = 1'b1;
      end
      ctl = 1'b0;
      if (ifa.halt) begin
         m_run = 1'b0; m_wait = 0; ctl = 1'b1;
      end else if (m_run && ifa.flush) begin
         m_pc = ifa.flush_pc; m_wait = 3; ctl = 1'b1;
      end else if (!m_run && ifa.start) begin
         m_run = 1'b1; m_pc = ifa.start_pc; m_wait = 3;
      end
      step();
      chk("a_busy", ifa.busy, m_run);
      chk("a_lerr", ifa.load_err, exp_err);
      if (!m_run) chk("a_idle_vld", ifa.out_valid, 1'b0);
      if (m_wait > 0) begin
         chk("a_latency", ifa.out_valid, m_wait == 1);
         m_wait--;
      end else if (held && !ctl) begin
         chk("a_hold_vld", ifa.out_valid, 1'b1);
         chk("a_hold_pc",  ifa.out_pc, h_pc);
         chk("a_hold_ins", {ifa.instruction, 31'd0, ifa.out_oob}, {h_ins, 31'd0, h_oob});
      end
   endtask

   task automatic wait_a(input string tag, input int lim);
      int t = 0;
      while (!ifa.out_valid && t < lim) begin
         cyc_a();
         t++;
      end
      chk({tag, "_vld"}, ifa.out_valid, 1'b1);
   endtask

   task automatic clr_a();
      ifa.start = 0; ifa.halt = 0; ifa.flush = 0; ifa.load_en = 0;
   endtask

   task automatic halt_a();
      clr_a(); ifa.halt = 1; cyc_a(); ifa.halt = 0;
   endtask

   // Start instance B at pc and expect the next n entries sequentially.
   task automatic stream_b(input logic [31:0] pc, input int n);
      int got = 0;
      logic [31:0] e_pc;
      e_pc = pc;
      ifb.start = 1; ifb.start_pc = pc; ifb.out_ready = 1;
      step();
      ifb.start = 0;
      for (int t = 0; t < n + 6 && got < n; t++) begin
         if (ifb.out_valid) begin
            chk("b_pc",  ifb.out_pc, e_pc);
            chk("b_ins", ifb.instruction, exp_ins_b(e_pc));
            chk("b_oob", ifb.out_oob, (e_pc >> 2) >= INS);
            e_pc = e_pc + 4;
            got++;
         end
         step();
      end
      chk("b_count", got, n);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      ifa.start = 0; ifa.start_pc = 0; ifa.halt = 0; ifa.flush = 0; ifa.flush_pc = 0;
      ifa.out_ready = 0; ifa.load_en = 0; ifa.load_addr = 0; ifa.load_data = 0;
      ifb.start = 0; ifb.start_pc = 0; ifb.halt = 0; ifb.flush = 0; ifb.flush_pc = 0;
      ifb.out_ready = 0; ifb.load_en = 0; ifb.load_addr = 0; ifb.load_data = 0;
      rst_a = 1; rst_b = 1;
      step(); step();
      chk("rst_vld",  ifa.out_valid, 1'b0);
      chk("rst_ins",  ifa.instruction, 32'd0);
      chk("rst_pc",   ifa.out_pc, 32'd0);
      chk("rst_oob",  ifa.out_oob, 1'b0);
      chk("rst_lerr", ifa.load_err, 1'b0);
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_b_vld", ifb.out_valid, 1'b0);
      rst_a = 0; rst_b = 0;

      // Image mem[i] = i + 100 into both instances through the load port.
      for (int i = 0; i < int'(INS); i++) begin
         ifa.load_en = 1; ifa.load_addr = 10'(i); ifa.load_data = 32'(i + 100);
         ifb.load_en = 1; ifb.load_addr = 10'(i); ifb.load_data = 32'(i + 100);
         cyc_a();
      end
      ifa.load_en = 0; ifb.load_en = 0;

      // Sequential stream with the consumer always ready: no bubbles after the first entry.
      ifa.out_ready = 1; ifa.start = 1; ifa.start_pc = 0;
      cyc_a(); clr_a();
      wait_a("t1", 4);
      for (int i = 0; i < 8; i++) begin
         chk("t1_thru", ifa.out_valid, 1'b1);
         cyc_a();
      end
      halt_a();

      // Stalled consumer fills the queue, release must resume without gaps.
      ifa.out_ready = 0; ifa.start = 1; ifa.start_pc = 0;
      cyc_a(); clr_a();
      for (int i = 0; i < 10; i++) cyc_a();
      ifa.out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         chk("t2_nogap", ifa.out_valid, 1'b1);
         cyc_a();
      end
      halt_a();

      // Redirect near pc 3; the first entry afterwards is pc 500.
      ifa.start = 1; ifa.start_pc = 0;
      cyc_a(); clr_a();
      for (int t = 0; t < 10 && !(ifa.out_valid && ifa.out_pc == 32'd3); t++) cyc_a();
      chk("t3_at3", ifa.out_pc, 32'd3);
      ifa.flush = 1; ifa.flush_pc = 500;
      cyc_a(); ifa.flush = 0;
      wait_a("t3", 4);
      chk("t3_pc",  ifa.out_pc, 32'd500);
      chk("t3_ins", ifa.instruction, 32'd600);
      for (int i = 0; i < 4; i++) cyc_a();
      halt_a();

      // End of memory: 998, 999 normal, then out-of-range entries.
      ifa.start = 1; ifa.start_pc = 998;
      cyc_a(); clr_a();
      wait_a("t4", 4);
      for (int i = 0; i < 2; i++) cyc_a();
      chk("t4_oob_pc", ifa.out_pc, 32'd1000);
      chk("t4_oob",    ifa.out_oob, 1'b1);
      chk("t4_ins0",   ifa.instruction, 32'd0);
      for (int i = 0; i < 3; i++) cyc_a();
      halt_a();

      // Load and start on the same edge; the new word is the first one fetched.
      ifa.load_en = 1; ifa.load_addr = 5; ifa.load_data = 32'hDEADBEEF;
      ifa.start = 1; ifa.start_pc = 5;
      cyc_a(); clr_a();
      wait_a("t5", 4);
      chk("t5_first", ifa.instruction, 32'hDEADBEEF);
      ifa.load_en = 1; ifa.load_addr = 7; ifa.load_data = 32'h0;
      cyc_a(); ifa.load_en = 0;
      for (int i = 0; i < 4; i++) cyc_a();
      halt_a();
      ifa.load_en = 1; ifa.load_addr = 10'd1000; ifa.load_data = 32'h1;
      cyc_a(); ifa.load_en = 0;
      ifa.start = 1; ifa.start_pc = 6;
      cyc_a(); clr_a();
      wait_a("t5b", 4);
      chk("t5_pc6",  ifa.instruction, 32'd106);
      cyc_a();
      chk("t5_kept", ifa.instruction, 32'd107);
      halt_a();

      // Byte-addressed instance: aligned, unaligned and end-of-memory streams.
      stream_b(32'd8, 3);
      ifb.halt = 1; step(); ifb.halt = 0;
      chk("b_halt_busy", ifb.busy, 1'b0);
      stream_b(32'd9, 2);
      ifb.halt = 1; step(); ifb.halt = 0;
      stream_b(32'd3992, 3);
      chk("b_busy", ifb.busy, 1'b1);
      rst_b = 1; step(); rst_b = 0;
      chk("b_rst_vld",  ifb.out_valid, 1'b0);
      chk("b_rst_busy", ifb.busy, 1'b0);

      // Randomised control, back-pressure and loads against the model.
      for (int c = 0; c < 3000; c++) begin
         int thr;
         thr = 4 - (c / 250) % 3;
         ifa.out_ready = ($urandom_range(0, 3) < thr);
         ifa.flush     = ($urandom_range(0, 39) == 0);
         ifa.flush_pc  = $urandom_range(0, 1010);
         ifa.halt      = ($urandom_range(0, 99) == 0);
         ifa.start     = ($urandom_range(0, 3) == 0);
         ifa.start_pc  = $urandom_range(0, 1010);
         ifa.load_en   = ($urandom_range(0, 7) == 0);
         ifa.load_addr = 10'($urandom_range(0, 1023));
         ifa.load_data = $urandom;
         cyc_a();
      end
      clr_a();

      // Reset in the middle of a stream.
      ifa.out_ready = 0; ifa.start = 1; ifa.start_pc = 20;
      cyc_a(); clr_a();
      for (int i = 0; i < 4; i++) cyc_a();
      rst_a = 1; step(); rst_a = 0;
      m_run = 0; m_wait = 0;
      chk("a_rst_vld",  ifa.out_valid, 1'b0);
      chk("a_rst_busy", ifa.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
